// File: rtl/pong_pkg.sv
// Shared Pong types: match state encodings, winner codes and the ball speed width.
package pong_pkg;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StServeWait  = 3'd1,
    StServeDelay = 3'd2,
    StRally      = 3'd3,
    StPointPause = 3'd4,
    StGameOver   = 3'd5
  } match_state_e;

  localparam logic [1:0] WinNone  = 2'b00;
  localparam logic [1:0] WinLeft  = 2'b01;
  localparam logic [1:0] WinRight = 2'b10;

  localparam int unsigned SpeedW = 4;

  function automatic logic [SpeedW-1:0] sat_inc(input logic [SpeedW-1:0] v,
                                                input logic [SpeedW-1:0] max);
    return (v >= max) ? max : v + 1'b1;
  endfunction

endpackage

// File: rtl/match_ctl_if.sv
// Event and control signals between the match controller and the game datapath.
interface match_ctl_if;
  import pong_pkg::*;

  logic              enable;
  logic              frame_tick;
  logic              start;
  logic              difficulty;
  logic              paddle_hit;
  logic              miss_left;
  logic              miss_right;
  logic              ball_launch;
  logic              ball_hold;
  logic              ball_dir;
  logic [SpeedW-1:0] ball_speed;
  logic [3:0]        score_l;
  logic [3:0]        score_r;
  logic [1:0]        winner;
  logic [2:0]        match_state;

  // master: the match controller; slave: the screen controller / datapath side
  modport master (
    input  enable, frame_tick, start, difficulty, paddle_hit, miss_left, miss_right,
    output ball_launch, ball_hold, ball_dir, ball_speed, score_l, score_r, winner,
    match_state
  );

  modport slave (
    output enable, frame_tick, start, difficulty, paddle_hit, miss_left, miss_right,
    input  ball_launch, ball_hold, ball_dir, ball_speed, score_l, score_r, winner,
    match_state
  );

endinterface

// File: rtl/match_ctl_frame_timer.sv
// Loadable frame-tick down-counter; done pulses on the tick that brings the count to 0.
module frame_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  output logic             done
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    done    = 1'b0;
    if (load) begin
      count_d = load_value;
    end else if (tick) begin
      // A count of 0 or 1 expires on this tick, so a zero load still takes one tick
      done    = (count_q <= Width'(1));
      count_d = (count_q == '0) ? '0 : count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/match_ctl.sv
// Pong match sequencer: serve, rally, point pause and game over, with scores and ball speed.
module match_ctl
  import pong_pkg::*;
#(
  parameter int unsigned WIN_SCORE     = 7,
  parameter int unsigned SERVE_FRAMES  = 60,
  parameter int unsigned POINT_FRAMES  = 90,
  parameter int unsigned SPEED_EASY    = 2,
  parameter int unsigned SPEED_HARD    = 4,
  parameter int unsigned SPEED_MAX     = 8,
  parameter int unsigned HITS_PER_STEP = 4
) (
  input logic         clk,
  input logic         rst,
  match_ctl_if.master bus
);

  localparam int unsigned TimerMax = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int unsigned TimerW   = (TimerMax < 2) ? 1 : $clog2(TimerMax + 1);
  localparam int unsigned HitW     = (HITS_PER_STEP < 2) ? 1 : $clog2(HITS_PER_STEP);

  localparam logic [3:0]        WinScore = 4'(WIN_SCORE);
  localparam logic [SpeedW-1:0] SpdEasy  = SpeedW'(SPEED_EASY);
  localparam logic [SpeedW-1:0] SpdHard  = SpeedW'(SPEED_HARD);
  localparam logic [SpeedW-1:0] SpdMax   = SpeedW'(SPEED_MAX);
  localparam logic [HitW-1:0]   HitLast  = HitW'(HITS_PER_STEP - 1);

  match_state_e      state_q, state_d;
  logic              start_q;
  logic              launch_q, launch_d;
  logic              hold_q, hold_d;
  logic              dir_q, dir_d;
  logic [SpeedW-1:0] speed_q, speed_d;
  logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]        winner_q, winner_d;
  logic [HitW-1:0]   hits_q, hits_d;

  logic start_edge, load_serve, load_point, timer_tick, timer_done;

  assign start_edge = bus.start & ~start_q;
  assign timer_tick = bus.frame_tick & ((state_q == StServeDelay) | (state_q == StPointPause));

  frame_timer #(
    .Width (TimerW)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .tick       (timer_tick),
    .load       (load_serve | load_point),
    .load_value (load_serve ? TimerW'(SERVE_FRAMES) : TimerW'(POINT_FRAMES)),
    .done       (timer_done)
  );

  always_comb begin
    state_d    = state_q;
    launch_d   = 1'b0;
    dir_d      = dir_q;
    speed_d    = speed_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    winner_d   = winner_q;
    hits_d     = hits_q;
    load_serve = 1'b0;
    load_point = 1'b0;

    if (!bus.enable) begin
      state_d   = StIdle;
      score_l_d = '0;
      score_r_d = '0;
      winner_d  = WinNone;
      hits_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StServeWait;
        StServeWait: begin
          if (start_edge) begin
            state_d    = StServeDelay;
            load_serve = 1'b1;
          end
        end
        StServeDelay: begin
          if (timer_done) begin
            state_d  = StRally;
            launch_d = 1'b1;
            speed_d  = bus.difficulty ? SpdHard : SpdEasy;
            hits_d   = '0;
          end
        end
        StRally: begin
          // Misses outrank a same-cycle paddle hit; a double miss is replayed unscored
          if (bus.miss_left && bus.miss_right) begin
            state_d    = StPointPause;
            load_point = 1'b1;
          end else if (bus.miss_left || bus.miss_right) begin
            dir_d     = bus.miss_right;
            score_r_d = score_r_q + {3'b000, bus.miss_left};
            score_l_d = score_l_q + {3'b000, bus.miss_right};
            if (score_r_d == WinScore || score_l_d == WinScore) begin
              state_d  = StGameOver;
              winner_d = bus.miss_left ? WinRight : WinLeft;
            end else begin
              state_d    = StPointPause;
              load_point = 1'b1;
            end
          end else if (bus.paddle_hit) begin
            if (hits_q == HitLast) begin
              hits_d  = '0;
              speed_d = sat_inc(speed_q, SpdMax);
            end else begin
              hits_d = hits_q + 1'b1;
            end
          end
        end
        StPointPause: if (timer_done) state_d = StServeWait;
        StGameOver: begin
          if (start_edge) begin
            state_d   = StServeWait;
            score_l_d = '0;
            score_r_d = '0;
            winner_d  = WinNone;
            hits_d    = '0;
            dir_d     = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    hold_d = (state_d != StRally);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      start_q   <= 1'b0;
      launch_q  <= 1'b0;
      hold_q    <= 1'b1;
      dir_q     <= 1'b0;
      speed_q   <= '0;
      score_l_q <= '0;
      score_r_q <= '0;
      winner_q  <= WinNone;
      hits_q    <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= bus.start;
      launch_q  <= launch_d;
      hold_q    <= hold_d;
      dir_q     <= dir_d;
      speed_q   <= speed_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      winner_q  <= winner_d;
      hits_q    <= hits_d;
    end
  end

  assign bus.match_state = state_q;
  assign bus.ball_launch = launch_q;
  assign bus.ball_hold   = hold_q;
  assign bus.ball_dir    = dir_q;
  assign bus.ball_speed  = speed_q;
  assign bus.score_l     = score_l_q;
  assign bus.score_r     = score_r_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_match_ctl.sv
// Directed bench for match_ctl: cycle vector table plus hand-written multi-cycle sequences.
module tb_match_ctl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  match_ctl_if bus ();

  match_ctl #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (3),
    .POINT_FRAMES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // inputs packed as {rst, enable, tick, start, difficulty, hit, miss_left, miss_right}
  typedef struct packed {
    logic [7:0] in;
    logic [2:0] st;
    logic       la;
    logic       ho;
    logic       dir;
    logic [3:0] sp;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] win;
  } vec_t;

  localparam int NVec = 25;
  vec_t vecs [NVec];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic vec_t mk(input logic [7:0] in, input logic [2:0] st, input logic la,
                              input logic ho, input logic dir, input logic [3:0] sp,
                              input logic [3:0] sl, input logic [3:0] sr, input logic [1:0] win);
    vec_t v;
    v.in = in; v.st = st; v.la = la; v.ho = ho; v.dir = dir;
    v.sp = sp; v.sl = sl; v.sr = sr; v.win = win;
    return v;
  endfunction

  task automatic step(input logic t, input logic s, input logic d, input logic h,
                      input logic l, input logic r);
    bus.frame_tick = t;
    bus.start      = s;
    bus.difficulty = d;
    bus.paddle_hit = h;
    bus.miss_left  = l;
    bus.miss_right = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ctl(input string nm, input logic [2:0] st, input logic la, input logic ho,
                         input logic [3:0] sp);
    n_vec++;
    if (bus.match_state !== st || bus.ball_launch !== la || bus.ball_hold !== ho ||
        bus.ball_speed !== sp) begin
      n_bad++;
      $display("FAIL %s: got state=%0d launch=%b hold=%b speed=%0d, want %0d %b %b %0d",
               nm, bus.match_state, bus.ball_launch, bus.ball_hold, bus.ball_speed,
               st, la, ho, sp);
    end
  endtask

  task automatic chk_score(input string nm, input logic dir, input logic [3:0] sl,
                           input logic [3:0] sr, input logic [1:0] win);
    n_vec++;
    if (bus.ball_dir !== dir || bus.score_l !== sl || bus.score_r !== sr ||
        bus.winner !== win) begin
      n_bad++;
      $display("FAIL %s: got dir=%b score=%0d:%0d winner=%b, want %b %0d:%0d %b",
               nm, bus.ball_dir, bus.score_l, bus.score_r, bus.winner, dir, sl, sr, win);
    end
  endtask

  task automatic serve(input string nm, input logic d, input logic [3:0] sp);
    step(1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
    chk_ctl({nm, "_delay"}, 3'd2, 1'b0, 1'b1, bus.ball_speed);
    step(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0);
    chk_ctl({nm, "_launch"}, 3'd3, 1'b1, 1'b0, sp);
    step(1'b0, 1'b0, d, 1'b0, 1'b0, 1'b0);
    chk_ctl({nm, "_launch_off"}, 3'd3, 1'b0, 1'b0, sp);
  endtask

  task automatic pause_done(input string nm, input logic [3:0] sp);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl(nm, 3'd1, 1'b0, 1'b1, sp);
  endtask

  task automatic hits(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = mk(8'b1000_0000, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0);
    vecs[1]  = mk(8'b0100_0000, 3'd1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0);
    vecs[2]  = mk(8'b0101_0000, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0);
    vecs[3]  = mk(8'b0111_0000, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0);
    vecs[4]  = mk(8'b0110_0000, 3'd2, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 2'd0);
    vecs[5]  = mk(8'b0110_1000, 3'd3, 1'b1, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 2'd0);
    vecs[6]  = mk(8'b0100_0000, 3'd3, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 2'd0);
    vecs[7]  = mk(8'b0100_0100, 3'd3, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 2'd0);
    vecs[8]  = mk(8'b0100_0100, 3'd3, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 2'd0);
    vecs[9]  = mk(8'b0100_0100, 3'd3, 1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 2'd0);
    vecs[10] = mk(8'b0100_0100, 3'd3, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 2'd0);
    vecs[11] = mk(8'b0100_0100, 3'd3, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 2'd0);
    vecs[12] = mk(8'b0100_0100, 3'd3, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 2'd0);
    vecs[13] = mk(8'b0100_0100, 3'd3, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 4'd0, 2'd0);
    vecs[14] = mk(8'b0100_0101, 3'd4, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd0, 2'd0);
    vecs[15] = mk(8'b0110_0000, 3'd4, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd0, 2'd0);
    vecs[16] = mk(8'b0110_0000, 3'd1, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd0, 2'd0);
    vecs[17] = mk(8'b0101_0000, 3'd2, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd0, 2'd0);
    vecs[18] = mk(8'b0110_0000, 3'd2, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd0, 2'd0);
    vecs[19] = mk(8'b0110_0000, 3'd2, 1'b0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd0, 2'd0);
    vecs[20] = mk(8'b0110_0000, 3'd3, 1'b1, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 2'd0);
    vecs[21] = mk(8'b0100_0011, 3'd4, 1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 2'd0);
    vecs[22] = mk(8'b0110_0010, 3'd4, 1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 2'd0);
    vecs[23] = mk(8'b0110_0000, 3'd1, 1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 2'd0);
    vecs[24] = mk(8'b0110_0000, 3'd1, 1'b0, 1'b1, 1'b1, 4'd2, 4'd1, 4'd0, 2'd0);

    rst        = 1'b1;
    bus.enable = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NVec; i++) begin
      rst        = vecs[i].in[7];
      bus.enable = vecs[i].in[6];
      step(vecs[i].in[5], vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1],
           vecs[i].in[0]);
      chk_ctl($sformatf("vec%0d_ctl", i), vecs[i].st, vecs[i].la, vecs[i].ho, vecs[i].sp);
      chk_score($sformatf("vec%0d_score", i), vecs[i].dir, vecs[i].sl, vecs[i].sr,
                vecs[i].win);
    end

    // Speed-up and saturation on easy difficulty
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("spd_serve_wait", 3'd1, 1'b0, 1'b1, 4'd0);
    serve("spd_serve", 1'b0, 4'd2);
    hits(4);
    chk_ctl("spd_step1", 3'd3, 1'b0, 1'b0, 4'd3);
    hits(20);
    chk_ctl("spd_reach_max", 3'd3, 1'b0, 1'b0, 4'd8);
    hits(28);
    chk_ctl("spd_saturate", 3'd3, 1'b0, 1'b0, 4'd8);
    chk_score("spd_score", 1'b0, 4'd0, 4'd0, 2'd0);

    // Left player wins 3:0, then a fresh match
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctl("win_pt1", 3'd4, 1'b0, 1'b1, 4'd8);
    chk_score("win_pt1_score", 1'b1, 4'd1, 4'd0, 2'd0);
    pause_done("win_pause1", 4'd8);
    serve("win_serve2", 1'b0, 4'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_score("win_pt2_score", 1'b1, 4'd2, 4'd0, 2'd0);
    pause_done("win_pause2", 4'd2);
    serve("win_serve3", 1'b0, 4'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_ctl("win_over", 3'd5, 1'b0, 1'b1, 4'd2);
    chk_score("win_over_score", 1'b1, 4'd3, 4'd0, 2'b01);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk_ctl("win_stray", 3'd5, 1'b0, 1'b1, 4'd2);
    chk_score("win_stray_score", 1'b1, 4'd3, 4'd0, 2'b01);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("win_restart", 3'd1, 1'b0, 1'b1, 4'd2);
    chk_score("win_restart_score", 1'b0, 4'd0, 4'd0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort mid-rally at 2:1
    serve("ab_serve1", 1'b0, 4'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pause_done("ab_pause1", 4'd2);
    serve("ab_serve2", 1'b0, 4'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pause_done("ab_pause2", 4'd2);
    serve("ab_serve3", 1'b0, 4'd2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_score("ab_2_1", 1'b0, 4'd2, 4'd1, 2'd0);
    pause_done("ab_pause3", 4'd2);
    serve("ab_serve4", 1'b0, 4'd2);
    bus.enable = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("ab_idle", 3'd0, 1'b0, 1'b1, 4'd2);
    chk_score("ab_idle_score", 1'b0, 4'd0, 4'd0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_score("ab_stray_off", 1'b0, 4'd0, 4'd0, 2'd0);
    bus.enable = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_ctl("ab_reenable", 3'd1, 1'b0, 1'b1, 4'd2);
    chk_score("ab_reenable_score", 1'b0, 4'd0, 4'd0, 2'd0);

    // Reset during the serve countdown
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("rst_pre", 3'd2, 1'b0, 1'b1, 4'd2);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("rst_mid", 3'd0, 1'b0, 1'b1, 4'd0);
    chk_score("rst_mid_score", 1'b0, 4'd0, 4'd0, 2'd0);
    rst        = 1'b0;
    bus.enable = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("rst_tick_idle", 3'd0, 1'b0, 1'b1, 4'd0);
    bus.enable = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_ctl("rst_enable", 3'd1, 1'b0, 1'b1, 4'd0);
    serve("rst_serve", 1'b1, 4'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/match_ctl.md
Name: match_ctl

Overview:
- Sequences one Pong match while the top-level controller is in GAME: serve wait, serve countdown, rally, point pause and game over.
- Keeps both players' scores and sets the ball datapath's launch, direction and speed, including difficulty-based speed and rally speed-up.
- Sits between the top-level screen controller and the game datapath (ball/paddle/renderer). Consumes frame ticks and ball events; drives registered control outputs.

Parameters:
- WIN_SCORE, 7: score that ends the match (1..15).
- SERVE_FRAMES, 60: frame ticks between serve request and launch.
- POINT_FRAMES, 90: frame ticks of pause after a point.
- SPEED_EASY, 2: base ball speed when difficulty=0.
- SPEED_HARD, 4: base ball speed when difficulty=1.
- SPEED_MAX, 8: speed saturation value.
- HITS_PER_STEP, 4: paddle hits per +1 speed step.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- enable  in  1  high while top-level state is GAME; low forces IDLE
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  mouse_left level; rising edge detected internally
- difficulty  in  1  0=easy, 1=hard; sampled at serve launch
- paddle_hit  in  1  one-cycle pulse: ball bounced off a paddle
- miss_left  in  1  one-cycle pulse: ball passed the left paddle
- miss_right  in  1  one-cycle pulse: ball passed the right paddle
- ball_launch  out  1  one-cycle pulse: release the ball
- ball_hold  out  1  ball frozen at centre
- ball_dir  out  1  0=serve toward left, 1=toward right
- ball_speed  out  4  current speed, pixels/frame
- score_l  out  4  left player score
- score_r  out  4  right player score
- winner  out  2  00 none, 01 left, 10 right
- match_state  out  3  current state code, for the renderer

Behaviour:
- All outputs are registered. Reset values:
  - state IDLE
  - ball_launch=0, ball_hold=1, ball_dir=0, ball_speed=0
  - score_l=0, score_r=0, winner=00
  - hit counter 0, start_q=0
- start_edge = start & ~start_q. start_q updates every cycle.
- Any input event takes effect at the next clock edge: one-cycle latency.
- enable=0 in any state: next state is IDLE; scores, winner and hit counter clear; ball_hold=1. This has priority over all other events.
- IDLE (000): enable=1 -> SERVE_WAIT.
- SERVE_WAIT (001): ball_hold=1. start_edge -> SERVE_DELAY; frame timer loads SERVE_FRAMES.
- SERVE_DELAY (010):
  - Each frame_tick decrements the timer.
  - The tick that reaches 0 moves the block to RALLY.
  - On entry to RALLY: ball_launch=1 for exactly one cycle, ball_hold=0.
  - ball_speed loads SPEED_EASY or SPEED_HARD from difficulty sampled that cycle; hit counter clears.
  - start_edge is ignored here.
- RALLY (011):
  - paddle_hit increments the hit counter. When the counter reaches HITS_PER_STEP it wraps to 0 and ball_speed += 1, saturating at SPEED_MAX.
  - miss_left -> score_r+1, ball_dir=0 (next serve toward the player who lost the point).
  - miss_right -> score_l+1, ball_dir=1.
  - miss_left and miss_right in the same cycle: no score change, ball_dir unchanged, go to POINT_PAUSE (replay).
  - A miss and paddle_hit in the same cycle: the miss wins and the hit is dropped.
  - After a scoring miss: if the new score equals WIN_SCORE -> GAME_OVER and winner is set in the same cycle; otherwise -> POINT_PAUSE.
- POINT_PAUSE (100): ball_hold=1. Timer loads POINT_FRAMES on entry and counts frame_ticks; reaching 0 -> SERVE_WAIT.
- GAME_OVER (101):
  - ball_hold=1; scores and winner hold.
  - start_edge -> SERVE_WAIT with scores, winner, hit counter and ball_dir cleared.
- miss_* and paddle_hit outside RALLY are ignored. frame_tick outside timed states is ignored.
- Scores are 4-bit and never exceed WIN_SCORE.
- A timer of 0 loaded on entry expires on the first frame_tick.
- Reset mid-rally returns every output to its reset value on the next edge.

Decomposition:
- Shared package pong_pkg holds:
  - match state encodings IDLE..GAME_OVER (3-bit)
  - winner codes
  - speed width constant (4)
- One sub-module, frame_timer:
  - loadable down-counter stepped by frame_tick
  - inputs: load, load_value
  - output: one-cycle done pulse when the count reaches 0
  - used for both the serve and point delays

Test Plan:
Benches run with SERVE_FRAMES=3, POINT_FRAMES=2, WIN_SCORE=3 unless stated.
- Serve: rst, enable=1, start rising edge, 3 frame_ticks -> match_state 001->010->011; ball_launch high exactly 1 cycle after the 3rd tick; ball_speed=2 (difficulty=0) or 4 (difficulty=1).
- Speed-up: in RALLY with easy difficulty, 4 paddle_hit pulses -> speed 3; 28 further hits -> saturates at 8, no wrap.
- Scoring to win: three miss_right pulses, each followed by POINT_PAUSE (2 ticks) and a serve -> score_l=3, winner=01, match_state=101; then start edge -> scores 0, match_state=001.
- Simultaneous miss: miss_left and miss_right in the same cycle -> scores unchanged, match_state=100; miss_right and paddle_hit together -> score_l+1, speed unchanged.
- Abort: enable dropped mid-RALLY with score 2:1 -> next cycle match_state=000, scores 0, ball_hold=1; stray miss_left in IDLE -> no change.
- Reset mid-SERVE_DELAY -> all outputs at reset values; the next frame_tick causes no transition out of IDLE until enable=1.
